// File: rtl/axi_read_burst_engine.sv
// -----------------------------------------------------------------------------
// axi_read_burst_engine
//
// AXI4 read-channel slave engine. Accepted AR requests wait in a small queue.
// Each burst is then served one beat at a time: the beat address is
// generated, the beat is fetched over a valid/ready memory port, and it is
// returned on the R channel with its ID, response code and RLAST. A request
// the engine cannot serve is answered with SLVERR beats and zero data, and
// the memory port is never touched for it.
//
// Parameters
//   IDW        AXI ID width
//   AW         address width
//   DW         data width in bits (power of two, 8..1024)
//   FIFO_DEPTH AR queue entries (power of two, >= 2)
//
// Ports
//   clk, resetn                 clock (rising edge), synchronous active-low reset
//   s_axi_ar*                   AR channel in; s_axi_arready = queue not full
//   s_axi_r*                    R channel out (rid/rdata/rresp/rlast/rvalid), rready in
//   mem_req_valid/ready/addr    beat fetch request to the backend
//   mem_rsp_valid/data/err      backend response, one per accepted request
// -----------------------------------------------------------------------------
module axi_read_burst_engine #(
  parameter int IDW        = 12,
  parameter int AW         = 32,
  parameter int DW         = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic [IDW-1:0] s_axi_arid,
  input  logic [AW-1:0]  s_axi_araddr,
  input  logic [7:0]     s_axi_arlen,
  input  logic [2:0]     s_axi_arsize,
  input  logic [1:0]     s_axi_arburst,
  input  logic           s_axi_arvalid,
  output logic           s_axi_arready,
  output logic [IDW-1:0] s_axi_rid,
  output logic [DW-1:0]  s_axi_rdata,
  output logic [1:0]     s_axi_rresp,
  output logic           s_axi_rlast,
  output logic           s_axi_rvalid,
  input  logic           s_axi_rready,
  output logic           mem_req_valid,
  input  logic           mem_req_ready,
  output logic [AW-1:0]  mem_req_addr,
  input  logic           mem_rsp_valid,
  input  logic [DW-1:0]  mem_rsp_data,
  input  logic           mem_rsp_err
);

  localparam int PW       = $clog2(FIFO_DEPTH);
  localparam int MAX_SIZE = $clog2(DW / 8);

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_RESP,
    S_ERR
  } state_e;

  // ---------------------------------------------------------------------------
  // AR queue: one array per field, pointers carry an extra wrap bit so that
  // full and empty can be told apart.
  // ---------------------------------------------------------------------------
  logic [IDW-1:0] q_id_mem    [FIFO_DEPTH];
  logic [AW-1:0]  q_addr_mem  [FIFO_DEPTH];
  logic [7:0]     q_len_mem   [FIFO_DEPTH];
  logic [2:0]     q_size_mem  [FIFO_DEPTH];
  logic [1:0]     q_burst_mem [FIFO_DEPTH];

  logic [PW:0] wr_ptr_q;
  logic [PW:0] rd_ptr_q;
  logic        rst_done_q;   // holds arready low through the reset cycle
  logic        q_empty;
  logic        q_full;
  logic        q_push;
  logic        q_pop;

  assign q_empty       = (wr_ptr_q == rd_ptr_q);
  assign q_full        = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                         (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign s_axi_arready = rst_done_q && !q_full;
  assign q_push        = s_axi_arvalid && s_axi_arready;

  always_ff @(posedge clk) begin
    if (q_push) begin
      q_id_mem[wr_ptr_q[PW-1:0]]    <= s_axi_arid;
      q_addr_mem[wr_ptr_q[PW-1:0]]  <= s_axi_araddr;
      q_len_mem[wr_ptr_q[PW-1:0]]   <= s_axi_arlen;
      q_size_mem[wr_ptr_q[PW-1:0]]  <= s_axi_arsize;
      q_burst_mem[wr_ptr_q[PW-1:0]] <= s_axi_arburst;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rst_done_q <= 1'b0;
    end else begin
      rst_done_q <= 1'b1;
      if (q_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (q_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  logic [IDW-1:0] head_id;
  logic [AW-1:0]  head_addr;
  logic [7:0]     head_len;
  logic [2:0]     head_size;
  logic [1:0]     head_burst;

  assign head_id    = q_id_mem[rd_ptr_q[PW-1:0]];
  assign head_addr  = q_addr_mem[rd_ptr_q[PW-1:0]];
  assign head_len   = q_len_mem[rd_ptr_q[PW-1:0]];
  assign head_size  = q_size_mem[rd_ptr_q[PW-1:0]];
  assign head_burst = q_burst_mem[rd_ptr_q[PW-1:0]];

  // ---------------------------------------------------------------------------
  // Request legality. The 4 KB check works inside the page offset: the
  // aligned start offset plus the total burst length must not pass 4096.
  // 17 bits covers 4095 + 256 * 128.
  // ---------------------------------------------------------------------------
  logic [16:0] incr_end;
  logic        head_bad;

  always_comb begin
    incr_end = ({5'd0, head_addr[11:0]} & ~((17'd1 << head_size) - 17'd1)) +
               ((17'(head_len) + 17'd1) << head_size);
    head_bad = 1'b0;
    if (int'(head_size) > MAX_SIZE) head_bad = 1'b1;
    case (head_burst)
      BURST_FIXED: ;
      BURST_INCR:  if (incr_end > 17'd4096) head_bad = 1'b1;
      BURST_WRAP: begin
        case (head_len)
          8'd1, 8'd3, 8'd7, 8'd15: ;
          default: head_bad = 1'b1;
        endcase
      end
      default:     head_bad = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Burst engine
  // ---------------------------------------------------------------------------
  state_e         state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [7:0]     len_q, len_d;
  logic [2:0]     size_q, size_d;
  logic [1:0]     burst_q, burst_d;
  logic [IDW-1:0] id_q, id_d;
  logic [7:0]     beat_q, beat_d;
  logic [DW-1:0]  data_q, data_d;
  logic [1:0]     resp_q, resp_d;

  // Address of the following beat. INCR realigns so that an unaligned first
  // beat is followed by aligned ones; WRAP folds back to the lower bound when
  // the next address would reach the top of the wrap window.
  logic [AW-1:0] beat_bytes;
  logic [AW-1:0] wrap_span;
  logic [AW-1:0] wrap_lower;
  logic [AW-1:0] seq_addr;
  logic [AW-1:0] next_addr;
  logic          last_beat;

  always_comb begin
    beat_bytes = AW'(1) << size_q;
    wrap_span  = (AW'(len_q) + AW'(1)) << size_q;
    wrap_lower = addr_q & ~(wrap_span - AW'(1));
    seq_addr   = addr_q + beat_bytes;
    case (burst_q)
      BURST_FIXED: next_addr = addr_q;
      BURST_INCR:  next_addr = (addr_q & ~(beat_bytes - AW'(1))) + beat_bytes;
      default:     next_addr = (seq_addr == wrap_lower + wrap_span) ? wrap_lower : seq_addr;
    endcase
  end

  assign last_beat = (beat_q == len_q);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      id_q    <= '0;
      beat_q  <= '0;
      data_q  <= '0;
      resp_q  <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      id_q    <= id_d;
      beat_q  <= beat_d;
      data_q  <= data_d;
      resp_q  <= resp_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    size_d        = size_q;
    burst_d       = burst_q;
    id_d          = id_q;
    beat_d        = beat_q;
    data_d        = data_q;
    resp_d        = resp_q;
    q_pop         = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = addr_q;
    s_axi_rvalid  = 1'b0;
    s_axi_rid     = '0;
    s_axi_rdata   = '0;
    s_axi_rresp   = RESP_OKAY;
    s_axi_rlast   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!q_empty) begin
          q_pop   = 1'b1;
          addr_d  = head_addr;
          len_d   = head_len;
          size_d  = head_size;
          burst_d = head_burst;
          id_d    = head_id;
          beat_d  = '0;
          state_d = head_bad ? S_ERR : S_FETCH;
        end
      end

      S_FETCH: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = S_WAIT;
      end

      S_WAIT: begin
        if (mem_rsp_valid) begin
          data_d  = mem_rsp_data;
          resp_d  = mem_rsp_err ? RESP_SLVERR : RESP_OKAY;
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        s_axi_rvalid = 1'b1;
        s_axi_rid    = id_q;
        s_axi_rdata  = data_q;
        s_axi_rresp  = resp_q;
        s_axi_rlast  = last_beat;
        if (s_axi_rready) begin
          if (last_beat) begin
            state_d = S_IDLE;
          end else begin
            beat_d  = beat_q + 8'd1;
            addr_d  = next_addr;
            state_d = S_FETCH;
          end
        end
      end

      S_ERR: begin
        s_axi_rvalid = 1'b1;
        s_axi_rid    = id_q;
        s_axi_rresp  = RESP_SLVERR;
        s_axi_rlast  = last_beat;
        if (s_axi_rready) begin
          if (last_beat) state_d = S_IDLE;
          else           beat_d  = beat_q + 8'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
